// File: rtl/perf_counter_ctrl_if.sv
// Register-access handshake between the core and the performance counter bank.
interface perf_counter_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/perf_counter_ctrl.sv
// Filtered, saturating event counter bank with memory-mapped counter/CTRL/MODE/OVF
// registers behind a one-shot mem_read/mem_write/mem_resp handshake.
module perf_counter_ctrl #(
  parameter int NUM_CTRS    = 8,
  parameter int width       = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CTRS-1:0] events,
  perf_counter_ctrl_if.slave  bus,
  output logic [NUM_CTRS-1:0] overflow
);

  localparam int RW = $clog2(HOLD_CYCLES + 2);
  localparam logic [RW-1:0] RUN_ARM  = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RUN_SAT  = RW'(HOLD_CYCLES + 1);
  localparam logic [3:0]    IDX_CTRL = 4'(NUM_CTRS);
  localparam logic [3:0]    IDX_MODE = 4'(NUM_CTRS + 1);
  localparam logic [3:0]    IDX_OVF  = 4'(NUM_CTRS + 2);

  typedef enum logic [1:0] {IDLE, RESP, WAIT_DROP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [width-1:0]    r_cnt     [NUM_CTRS];
  logic [width-1:0]    w_cnt_nxt [NUM_CTRS];
  logic [RW-1:0]       r_run     [NUM_CTRS];
  logic [RW-1:0]       w_run_nxt [NUM_CTRS];
  logic [NUM_CTRS-1:0] r_ctrl, w_ctrl_nxt;
  logic [NUM_CTRS-1:0] r_mode, w_mode_nxt;
  logic [NUM_CTRS-1:0] r_ovf, w_ovf_nxt;
  logic [NUM_CTRS-1:0] w_fire, w_ovf_set, w_ovf_clr;
  logic [15:0]         r_rdata, w_rdata;
  logic [3:0]          w_idx;
  logic                w_req, w_acc, w_wr, w_rd;
  logic                w_unused;

  assign w_idx    = bus.mem_address[4:1];
  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_acc    = (r_state == IDLE) && w_req;
  assign w_wr     = w_acc && bus.mem_write;
  assign w_rd     = w_acc && !bus.mem_write;
  assign w_unused = ^{bus.mem_address[15:5], bus.mem_address[0], bus.mem_wdata};

  assign bus.mem_resp  = (r_state == RESP);
  assign bus.mem_rdata = r_rdata;
  assign overflow      = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_req) w_state_nxt = RESP;
      RESP:      w_state_nxt = WAIT_DROP;
      WAIT_DROP: if (!w_req) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      if (w_idx == 4'(i)) w_rdata = 16'(r_cnt[i]);
    end
    if (w_idx == IDX_CTRL) w_rdata = 16'(r_ctrl);
    if (w_idx == IDX_MODE) w_rdata = 16'(r_mode);
    if (w_idx == IDX_OVF)  w_rdata = 16'(r_ovf);
  end

  // The run filter advances independently of preloads; a preload only
  // suppresses the counter update for that edge.
  always_comb begin
    w_fire     = '0;
    w_ovf_set  = '0;
    w_ovf_clr  = '0;
    w_ctrl_nxt = r_ctrl;
    w_mode_nxt = r_mode;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_run_nxt[i] = '0;
      if (r_ctrl[i] && events[i]) begin
        w_fire[i]    = r_mode[i] || (r_run[i] == RUN_ARM);
        w_run_nxt[i] = (r_run[i] == RUN_SAT) ? RUN_SAT : r_run[i] + 1'b1;
      end
      if (w_wr && (w_idx == 4'(i))) begin
        w_cnt_nxt[i] = bus.mem_wdata[width-1:0];
      end else if (w_fire[i]) begin
        if (r_cnt[i] == '1) w_ovf_set[i] = 1'b1;
        else                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
    if (w_wr && (w_idx == IDX_CTRL)) w_ctrl_nxt = bus.mem_wdata[NUM_CTRS-1:0];
    if (w_wr && (w_idx == IDX_MODE)) w_mode_nxt = bus.mem_wdata[NUM_CTRS-1:0];
    if (w_wr && (w_idx == IDX_OVF))  w_ovf_clr  = bus.mem_wdata[NUM_CTRS-1:0];
    w_ovf_nxt = (r_ovf & ~w_ovf_clr) | w_ovf_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rdata <= '0;
      r_ctrl  <= '1;
      r_mode  <= '0;
      r_ovf   <= '0;
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        r_cnt[i] <= '0;
        r_run[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rd ? w_rdata : '0;
      r_ctrl  <= w_ctrl_nxt;
      r_mode  <= w_mode_nxt;
      r_ovf   <= w_ovf_nxt;
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        r_run[i] <= w_run_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed bench for perf_counter_ctrl with a spec-level reference model checked every cycle.
module tb_perf_counter_ctrl;

  localparam int N    = 8;
  localparam int W    = 16;
  localparam int H    = 2;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] events = '0;
  logic [N-1:0] overflow;
  int           checks = 0;
  int           failures = 0;

  perf_counter_ctrl_if bus_if ();

  perf_counter_ctrl #(.NUM_CTRS(N), .width(W), .HOLD_CYCLES(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .events   (events),
    .bus      (bus_if),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: registers as plain integers, run filter as a length of the current high run.
  int           m_cnt [N];
  int           m_run [N];
  logic [N-1:0] m_ctrl = '1;
  logic [N-1:0] m_mode = '0;
  logic [N-1:0] m_ovf  = '0;
  logic         m_resp = 1'b0;
  logic         m_wait = 1'b0;
  logic [15:0]  m_rdata = '0;

  function automatic logic [15:0] m_reg(input int idx);
    if (idx < N)      return 16'(m_cnt[idx]);
    if (idx == N)     return 16'(m_ctrl);
    if (idx == N + 1) return 16'(m_mode);
    if (idx == N + 2) return 16'(m_ovf);
    return 16'h0000;
  endfunction

  always @(posedge clk or negedge reset) begin
    int           idx;
    bit           req, wr, acc, fire;
    logic [15:0]  rd_val;
    logic [N-1:0] en, lvl, ovf_set;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_run[i] = 0;
      end
      m_ctrl = '1; m_mode = '0; m_ovf = '0;
      m_resp = 1'b0; m_wait = 1'b0; m_rdata = '0;
    end else begin
      idx     = int'(bus_if.mem_address[4:1]);
      req     = bus_if.mem_read || bus_if.mem_write;
      wr      = bus_if.mem_write;
      acc     = req && !m_resp && !m_wait;
      rd_val  = (acc && !wr) ? m_reg(idx) : 16'h0000;
      en      = m_ctrl;
      lvl     = m_mode;
      ovf_set = '0;
      for (int i = 0; i < N; i++) begin
        fire = 1'b0;
        if (en[i] && events[i]) begin
          m_run[i]++;
          fire = lvl[i] || (m_run[i] == H + 1);
        end else begin
          m_run[i] = 0;
        end
        if (acc && wr && idx == i)     m_cnt[i] = int'(bus_if.mem_wdata) & MAXV;
        else if (fire && m_cnt[i] == MAXV) ovf_set[i] = 1'b1;
        else if (fire)                 m_cnt[i]++;
      end
      if (acc && wr && idx == N)     m_ctrl = bus_if.mem_wdata[N-1:0];
      if (acc && wr && idx == N + 1) m_mode = bus_if.mem_wdata[N-1:0];
      if (acc && wr && idx == N + 2) m_ovf  = m_ovf & ~bus_if.mem_wdata[N-1:0];
      m_ovf   = m_ovf | ovf_set;
      m_wait  = m_resp || (m_wait && req);
      m_resp  = acc;
      m_rdata = rd_val;
    end
  end

  always @(negedge clk) begin
    check("resp", 16'(bus_if.mem_resp), 16'(m_resp));
    check("rdata", bus_if.mem_rdata, m_rdata);
    check("overflow", 16'(overflow), 16'(m_ovf));
  end

  task automatic bus_op(input bit rd, input bit wr, input int idx, input logic [15:0] wd,
                        input logic [N-1:0] ev, output logic [15:0] data);
    @(negedge clk);
    bus_if.mem_read    = rd;
    bus_if.mem_write   = wr;
    bus_if.mem_address = 16'(idx * 2);
    bus_if.mem_wdata   = wd;
    events             = events | ev;
    @(negedge clk);
    events = events & ~ev;
    check("resp_latency", 16'(bus_if.mem_resp), 16'h0001);
    data = bus_if.mem_rdata;
    bus_if.mem_read  = 1'b0;
    bus_if.mem_write = 1'b0;
    @(negedge clk);
    check("resp_width", 16'(bus_if.mem_resp), 16'h0000);
    @(negedge clk);
  endtask

  task automatic rd_chk(input int idx, input logic [15:0] exp, input string name);
    logic [15:0] v;
    bus_op(1'b1, 1'b0, idx, 16'h0000, '0, v);
    check(name, v, exp);
  endtask

  task automatic wr_reg(input int idx, input logic [15:0] val);
    logic [15:0] v;
    bus_op(1'b0, 1'b1, idx, val, '0, v);
    check("write_rdata", v, 16'h0000);
  endtask

  task automatic run_pulse(input int i, input int n);
    @(negedge clk);
    events[i] = 1'b1;
    repeat (n) @(negedge clk);
    events[i] = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int pulses;
    bus_if.mem_read    = 1'b0;
    bus_if.mem_write   = 1'b0;
    bus_if.mem_address = '0;
    bus_if.mem_wdata   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i <= N + 2; i++)
      rd_chk(i, (i == N) ? 16'h00FF : 16'h0000, "reset_reg");

    run_pulse(0, 2);
    run_pulse(0, 5);
    rd_chk(0, 16'h0001, "run_mode_once");
    run_pulse(0, 3);
    rd_chk(0, 16'h0002, "run_mode_exact");

    wr_reg(N + 1, 16'h0002);
    run_pulse(1, 10);
    rd_chk(1, 16'h000A, "level_mode");
    wr_reg(N, 16'h00FD);
    run_pulse(1, 10);
    rd_chk(1, 16'h000A, "disabled_hold");

    wr_reg(2, 16'hFFFE);
    for (int k = 0; k < 3; k++) run_pulse(2, 3);
    rd_chk(2, 16'hFFFF, "saturate");
    rd_chk(N + 2, 16'h0004, "ovf_set");
    check("overflow_port_set", 16'(overflow), 16'h0004);
    wr_reg(N + 2, 16'h0004);
    rd_chk(N + 2, 16'h0000, "ovf_w1c");
    check("overflow_port_clr", 16'(overflow), 16'h0000);
    rd_chk(2, 16'hFFFF, "sat_kept");

    @(negedge clk);
    bus_if.mem_read    = 1'b1;
    bus_if.mem_address = 16'(3 * 2);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.mem_resp) pulses++;
    end
    bus_if.mem_read = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.mem_resp) pulses++;
    end
    check("held_read_pulses", 16'(pulses), 16'h0001);

    wr_reg(15, 16'h1234);
    rd_chk(15, 16'h0000, "unmapped_read");
    rd_chk(N, 16'h00FD, "unmapped_ctrl");
    rd_chk(N + 1, 16'h0002, "unmapped_mode");
    wr_reg(N, 16'h00FF);

    bus_op(1'b1, 1'b1, 4, 16'h0055, '0, v);
    check("rw_both_rdata", v, 16'h0000);
    rd_chk(4, 16'h0055, "rw_both_write");

    wr_reg(N + 1, 16'h000A);
    bus_op(1'b0, 1'b1, 3, 16'h0100, 8'h08, v);
    rd_chk(3, 16'h0100, "preload_wins");

    @(negedge clk);
    bus_if.mem_read    = 1'b1;
    bus_if.mem_address = 16'(1 * 2);
    @(posedge clk);
    #1;
    check("pre_reset_resp", 16'(bus_if.mem_resp), 16'h0001);
    #1;
    reset = 1'b0;
    #1;
    check("reset_resp_drop", 16'(bus_if.mem_resp), 16'h0000);
    check("reset_rdata_drop", bus_if.mem_rdata, 16'h0000);
    bus_if.mem_read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_chk(1, 16'h0000, "post_reset_cnt1");
    rd_chk(3, 16'h0000, "post_reset_cnt3");
    rd_chk(N, 16'h00FF, "post_reset_ctrl");
    rd_chk(N + 1, 16'h0000, "post_reset_mode");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
